// File: rtl/lcd_cmd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_cmd_pkg
//   Shared definitions for the LCD write-bus receive decoder.
//   - LCD controller opcodes recognised by the monitor
//   - decoder FSM state encoding (exported on STATE_DBG of the top)
//   - FRMCTR1 parameter count and a helper that qualifies FRMCTR1 parameters
//   Optional feature macro used by the top: LCD_SHADOW_FRMCTR_EN
// -----------------------------------------------------------------------------
package lcd_cmd_pkg;

   // Controller opcodes
   localparam logic [7:0] OP_NOP     = 8'h00;
   localparam logic [7:0] OP_SWRESET = 8'h01;
   localparam logic [7:0] OP_SLPOUT  = 8'h11;
   localparam logic [7:0] OP_DISPON  = 8'h29;
   localparam logic [7:0] OP_FRMCTR1 = 8'hB1;
   localparam logic [7:0] OP_FRMCTR2 = 8'hB2;
   localparam logic [7:0] OP_FRMCTR3 = 8'hB3;

   // FRMCTR1 carries three parameter bytes
   localparam int FRMCTR1_NPARAM = 3;

   // Decoder FSM states
   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_IDLE  = 2'd1,
      S_SHIFT = 2'd2
   } state_t;

   // True when a parameter byte with index idx, following command cmd,
   // belongs to the FRMCTR1 shadow set.
   function automatic logic is_frmctr1_param(input logic [7:0] cmd,
                                             input logic [7:0] idx);
      return (cmd == OP_FRMCTR1) && (idx < 8'(FRMCTR1_NPARAM));
   endfunction

endpackage

// File: rtl/lcd_spi_sync.sv
// -----------------------------------------------------------------------------
// lcd_spi_sync
//   Multi-flop synchronizer for the asynchronous LCD write-bus pins, plus
//   rising-edge detection on the synchronized SCL and CS levels.
//   Ports:
//     clk, rst          system clock, synchronous active-high reset
//     scl, mosi, cs,
//     dc, lcd_rstn      raw bus pins (asynchronous to clk)
//     mosi_s, cs_s,
//     dc_s, lcd_rstn_s  synchronized levels (all with identical delay)
//     scl_rise          one-clk pulse on synchronized SCL 0->1
//     cs_rise           one-clk pulse on synchronized CS 0->1
//   SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module lcd_spi_sync
   import lcd_cmd_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic mosi,
   input  logic cs,
   input  logic dc,
   input  logic lcd_rstn,
   output logic mosi_s,
   output logic cs_s,
   output logic dc_s,
   output logic lcd_rstn_s,
   output logic scl_rise,
   output logic cs_rise
);

   localparam int LAST = SYNC_STAGES - 1;

   // Bit order inside each stage: {lcd_rstn, dc, cs, mosi, scl}.
   // Reset to the idle bus: CS deasserted and LCD not in reset, so leaving
   // RST never produces a spurious LCD reset or edge.
   localparam logic [4:0] IDLE_BUS = 5'b10100;

   logic [4:0] stage [SYNC_STAGES];
   logic       scl_prev;
   logic       cs_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage[i] <= IDLE_BUS;
         end
         scl_prev <= 1'b0;
         cs_prev  <= 1'b1;
      end else begin
         stage[0] <= {lcd_rstn, dc, cs, mosi, scl};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
         scl_prev <= stage[LAST][0];
         cs_prev  <= stage[LAST][2];
      end
   end

   assign mosi_s     = stage[LAST][1];
   assign cs_s       = stage[LAST][2];
   assign dc_s       = stage[LAST][3];
   assign lcd_rstn_s = stage[LAST][4];
   assign scl_rise   = stage[LAST][0] & ~scl_prev;
   assign cs_rise    = stage[LAST][2] & ~cs_prev;

endmodule

// File: rtl/lcd_spi_rx_decoder.sv
// -----------------------------------------------------------------------------
// lcd_spi_rx_decoder
//   Receive-side decoder for the 4-wire LCD write bus. Oversamples SCL/MOSI/
//   CS/DC/LCD_RSTN on CLK, rebuilds MSB-first bytes, tags each byte as a
//   command (DC=0) or parameter (DC=1) and numbers parameters since the last
//   command.
//   Ports:
//     CLK, RST          system clock, synchronous active-high reset
//     SCL, MOSI, CS,
//     DC, LCD_RSTN      observed bus pins (asynchronous)
//     BYTE_DATA         last decoded byte (holds between pulses)
//     BYTE_VALID        one-CLK pulse per decoded byte
//     BYTE_IS_CMD       1 when BYTE_DATA was sent with DC=0
//     PARAM_IDX         0-based parameter index, saturating at FFh
//     CMD_LATCHED       most recent command byte
//     FRAME_ERR         one-CLK pulse when CS rises mid-byte
//     LCD_IN_RESET      1 while synchronized LCD_RSTN is low
//     FRMCTR1_P0/P1/P2  shadow copies of the FRMCTR1 parameters
//     FRMCTR1_UPD       one-CLK pulse when FRMCTR1 parameter 2 is captured
//     STATE_DBG         current FSM state (lcd_cmd_pkg::state_t encoding)
//   Optional feature: define LCD_SHADOW_FRMCTR_EN to build the FRMCTR1
//   shadow registers; otherwise FRMCTR1_P* and FRMCTR1_UPD are tied to 0.
//
//   Output handshake: BYTE_VALID is a qualifier pulse with no ready/backpressure;
//   BYTE_DATA, BYTE_IS_CMD, PARAM_IDX and CMD_LATCHED are valid in the cycle
//   BYTE_VALID=1 and hold until the next pulse (or a reset).
// -----------------------------------------------------------------------------
module lcd_spi_rx_decoder
   import lcd_cmd_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SCL,
   input  logic       MOSI,
   input  logic       CS,
   input  logic       DC,
   input  logic       LCD_RSTN,
   output logic [7:0] BYTE_DATA,
   output logic       BYTE_VALID,
   output logic       BYTE_IS_CMD,
   output logic [7:0] PARAM_IDX,
   output logic [7:0] CMD_LATCHED,
   output logic       FRAME_ERR,
   output logic       LCD_IN_RESET,
   output logic [7:0] FRMCTR1_P0,
   output logic [7:0] FRMCTR1_P1,
   output logic [7:0] FRMCTR1_P2,
   output logic       FRMCTR1_UPD,
   output logic [1:0] STATE_DBG
);

   // --------------------------------------------------------------------------
   // Input synchronization
   // --------------------------------------------------------------------------
   logic mosi_s;
   logic cs_s;
   logic dc_s;
   logic lcd_rstn_s;
   logic scl_rise;
   logic cs_rise;

   lcd_spi_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk        (CLK),
      .rst        (RST),
      .scl        (SCL),
      .mosi       (MOSI),
      .cs         (CS),
      .dc         (DC),
      .lcd_rstn   (LCD_RSTN),
      .mosi_s     (mosi_s),
      .cs_s       (cs_s),
      .dc_s       (dc_s),
      .lcd_rstn_s (lcd_rstn_s),
      .scl_rise   (scl_rise),
      .cs_rise    (cs_rise)
   );

   // --------------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------------
   state_t     state;
   state_t     state_nxt;
   logic       shift_en;      // accept one MOSI bit this cycle
   logic       drop_partial;  // discard the bits collected so far
   logic       frame_err_set; // CS rose with an incomplete byte

   logic [2:0] bit_cnt;
   logic [6:0] shift_reg;
   logic [7:0] byte_reg;
   logic       dc_reg;
   logic       byte_pend;     // complete byte waiting to be published
   logic [7:0] param_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      shift_en      = 1'b0;
      drop_partial  = 1'b0;
      frame_err_set = 1'b0;

      if (!lcd_rstn_s) begin
         // LCD reset overrides everything; the partial byte is silently lost.
         state_nxt    = S_RESET;
         drop_partial = 1'b1;
      end else begin
         case (state)
            S_RESET: begin
               state_nxt    = S_IDLE;
               drop_partial = 1'b1;
            end
            S_IDLE: begin
               if (!cs_s) begin
                  state_nxt = S_SHIFT;
               end
            end
            S_SHIFT: begin
               // cs_rise wins over a coincident scl_rise: that bit is discarded.
               if (cs_rise) begin
                  state_nxt     = S_IDLE;
                  drop_partial  = 1'b1;
                  frame_err_set = (bit_cnt != 3'd0);
               end else if (scl_rise && !cs_s) begin
                  shift_en = 1'b1;
               end
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign STATE_DBG = state;

   // --------------------------------------------------------------------------
   // Bit assembly. The completed byte is parked for one cycle in byte_reg so
   // BYTE_VALID lands SYNC_STAGES+2 clocks after the SCL pin edge.
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         bit_cnt   <= 3'd0;
         shift_reg <= 7'd0;
         byte_reg  <= 8'd0;
         dc_reg    <= 1'b0;
         byte_pend <= 1'b0;
      end else begin
         byte_pend <= 1'b0;
         if (drop_partial) begin
            bit_cnt <= 3'd0;
         end else if (shift_en) begin
            shift_reg <= {shift_reg[5:0], mosi_s};
            bit_cnt   <= bit_cnt + 3'd1;   // wraps to 0 after the 8th bit
            if (bit_cnt == 3'd7) begin
               byte_reg  <= {shift_reg, mosi_s};
               dc_reg    <= dc_s;
               byte_pend <= 1'b1;
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Byte publication, command/parameter tracking
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         BYTE_DATA    <= 8'd0;
         BYTE_VALID   <= 1'b0;
         BYTE_IS_CMD  <= 1'b0;
         PARAM_IDX    <= 8'd0;
         CMD_LATCHED  <= 8'd0;
         FRAME_ERR    <= 1'b0;
         LCD_IN_RESET <= 1'b0;
         param_cnt    <= 8'd0;
      end else begin
         BYTE_VALID   <= 1'b0;
         FRAME_ERR    <= frame_err_set;
         LCD_IN_RESET <= ~lcd_rstn_s;
         if (!lcd_rstn_s) begin
            // A byte completing as the LCD enters reset is dropped with it.
            CMD_LATCHED <= 8'd0;
            param_cnt   <= 8'd0;
         end else if (byte_pend) begin
            BYTE_VALID  <= 1'b1;
            BYTE_DATA   <= byte_reg;
            BYTE_IS_CMD <= ~dc_reg;
            if (!dc_reg) begin
               // PARAM_IDX deliberately keeps its previous value on commands.
               CMD_LATCHED <= byte_reg;
               param_cnt   <= 8'd0;
            end else begin
               PARAM_IDX <= param_cnt;
               if (param_cnt != 8'hFF) begin
                  param_cnt <= param_cnt + 8'd1;
               end
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // FRMCTR1 shadow registers
   // --------------------------------------------------------------------------
`ifdef LCD_SHADOW_FRMCTR_EN
   logic shadow_load;

   // Uses the same qualifiers as the parameter path above, so the load lands
   // in the same cycle as the matching BYTE_VALID.
   assign shadow_load = byte_pend && lcd_rstn_s && dc_reg &&
                        is_frmctr1_param(CMD_LATCHED, param_cnt);

   // Cleared by RST only; an LCD reset leaves the last programmed values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         FRMCTR1_P0  <= 8'd0;
         FRMCTR1_P1  <= 8'd0;
         FRMCTR1_P2  <= 8'd0;
         FRMCTR1_UPD <= 1'b0;
      end else begin
         FRMCTR1_UPD <= 1'b0;
         if (shadow_load) begin
            case (param_cnt[1:0])
               2'd0:    FRMCTR1_P0 <= byte_reg;
               2'd1:    FRMCTR1_P1 <= byte_reg;
               2'd2: begin
                  FRMCTR1_P2  <= byte_reg;
                  FRMCTR1_UPD <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
`else
   assign FRMCTR1_P0  = 8'd0;
   assign FRMCTR1_P1  = 8'd0;
   assign FRMCTR1_P2  = 8'd0;
   assign FRMCTR1_UPD = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_spi_rx_decoder.sv
// -----------------------------------------------------------------------------
// tb_lcd_spi_rx_decoder
//   Self-checking bench for lcd_spi_rx_decoder. A byte-level reference model
//   (command/parameter bookkeeping and FRMCTR1 shadow) fills an expected queue;
//   a monitor pops it on every BYTE_VALID. Directed steps cover reset, framing
//   errors, back-to-back bytes, LCD reset, idle SCL and index saturation.
//   Honours LCD_SHADOW_FRMCTR_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_lcd_spi_rx_decoder;
  import lcd_cmd_pkg::*;

  localparam int SYNC = 2;
  localparam int W    = 25;   // {is_cmd, data, param_idx, cmd_latched}
`ifdef LCD_SHADOW_FRMCTR_EN
  localparam bit SHADOW_EN = 1'b1;
`else
  localparam bit SHADOW_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic       scl = 1'b0, mosi = 1'b0, cs = 1'b1, dc_pin = 1'b0, lcd_rstn = 1'b1;
  logic [7:0] byte_data, param_idx, cmd_latched, p0, p1, p2;
  logic       byte_valid, byte_is_cmd, frame_err, lcd_in_reset, upd;
  logic [1:0] state_dbg;

  lcd_spi_rx_decoder #(.SYNC_STAGES(SYNC)) dut (
    .CLK          (clk),
    .RST          (rst),
    .SCL          (scl),
    .MOSI         (mosi),
    .CS           (cs),
    .DC           (dc_pin),
    .LCD_RSTN     (lcd_rstn),
    .BYTE_DATA    (byte_data),
    .BYTE_VALID   (byte_valid),
    .BYTE_IS_CMD  (byte_is_cmd),
    .PARAM_IDX    (param_idx),
    .CMD_LATCHED  (cmd_latched),
    .FRAME_ERR    (frame_err),
    .LCD_IN_RESET (lcd_in_reset),
    .FRMCTR1_P0   (p0),
    .FRMCTR1_P1   (p1),
    .FRMCTR1_P2   (p2),
    .FRMCTR1_UPD  (upd),
    .STATE_DBG    (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  int valid_cnt = 0, fe_cnt = 0, upd_cnt = 0;
  int last_valid_cyc = 0, last_rise_cyc = 0;

  // reference model
  logic [7:0] model_cmd = 8'h00;
  logic [7:0] model_idx = 8'h00;
  int         model_cnt = 0;
  logic [7:0] exp_p [3] = '{8'h00, 8'h00, 8'h00};
  int         exp_upd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input bit full);
    model_cmd = 8'h00;
    model_cnt = 0;
    if (full) begin
      model_idx = 8'h00;
      exp_p     = '{8'h00, 8'h00, 8'h00};
    end
  endtask

  // Predict the effect of one complete byte.
  task automatic expect_byte(input logic [7:0] d, input logic dcv);
    if (!dcv) begin
      model_cmd = d;
      model_cnt = 0;
      exp_q.push_back({1'b1, d, model_idx, d});
    end else begin
      model_idx = 8'(model_cnt);
      if (SHADOW_EN && model_cmd == 8'hB1 && model_cnt < 3) begin
        exp_p[model_cnt] = d;
        if (model_cnt == 2) exp_upd++;
      end
      model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
      exp_q.push_back({1'b0, d, model_idx, model_cmd});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (upd) begin
      upd_cnt++;
      chk("upd_with_valid", {31'd0, byte_valid}, 32'd1);
    end
    if (frame_err && byte_valid) chk("valid_and_ferr", 32'd1, 32'd0);
    if (byte_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_byte: got %0h want none", byte_data);
      end else begin
        chk("byte", {7'd0, byte_is_cmd, byte_data, param_idx, cmd_latched}, {7'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] d, input int nbits, input logic dcv, input int half);
    for (int i = 0; i < nbits; i++) begin
      scl = 1'b0; mosi = d[7-i]; dc_pin = dcv;
      tick(half);
      scl = 1'b1; last_rise_cyc = cyc;
      tick(half);
    end
    scl = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input logic dcv, input int half);
    cs = 1'b0; tick(4);
    expect_byte(d, dcv);
    send_bits(d, 8, dcv, half);
    tick(4); cs = 1'b1; tick(8);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"},  {24'd0, byte_data},   32'd0);
    chk({tag, "_valid"}, {31'd0, byte_valid},  32'd0);
    chk({tag, "_iscmd"}, {31'd0, byte_is_cmd}, 32'd0);
    chk({tag, "_idx"},   {24'd0, param_idx},   32'd0);
    chk({tag, "_cmd"},   {24'd0, cmd_latched}, 32'd0);
    chk({tag, "_ferr"},  {31'd0, frame_err},   32'd0);
    chk({tag, "_inrst"}, {31'd0, lcd_in_reset}, 32'd0);
    chk({tag, "_p0"},    {24'd0, p0}, 32'd0);
    chk({tag, "_p1"},    {24'd0, p1}, 32'd0);
    chk({tag, "_p2"},    {24'd0, p2}, 32'd0);
    chk({tag, "_upd"},   {31'd0, upd}, 32'd0);
  endtask

  task automatic check_shadow(input string tag);
    chk({tag, "_p0"},  {24'd0, p0}, {24'd0, exp_p[0]});
    chk({tag, "_p1"},  {24'd0, p1}, {24'd0, exp_p[1]});
    chk({tag, "_p2"},  {24'd0, p2}, {24'd0, exp_p[2]});
    chk({tag, "_upd"}, upd_cnt, exp_upd);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int v0, f0;
    logic [7:0] r;
    logic [7:0] b1_params [3];

    // power-on reset
    rst = 1'b1; tick(3);
    check_all_zero("por");
    rst = 1'b0; tick(4);
    chk("por_state", {30'd0, state_dbg}, {30'd0, S_IDLE});

    // Step 1: warm-up traffic, then RST mid-byte
    frame(8'($urandom_range(0, 255)), 1'b0, 4);
    frame(8'($urandom_range(0, 255)), 1'b1, 3);
    frame(8'($urandom_range(0, 255)), 1'b1, 2);
    cs = 1'b0; tick(4);
    send_bits(8'($urandom_range(0, 255)), 4, 1'b1, 4);
    rst = 1'b1; tick(2);
    check_all_zero("rst_mid");
    tick(2);
    cs = 1'b1; rst = 1'b0;
    model_reset(1'b1);
    exp_upd = upd_cnt;
    tick(8);
    v0 = valid_cnt;
    frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 4);
    chk("post_rst_valid", valid_cnt - v0, 1);

    // Step 2: FRMCTR1 write, SCL = CLK/8, latency check on each byte
    b1_params = '{8'h05, 8'h3C, 8'h3C};
    v0 = valid_cnt;
    frame(8'hB1, 1'b0, 4);
    chk("lat_cmd", last_valid_cyc - last_rise_cyc, SYNC + 2);
    for (int k = 0; k < 3; k++) begin
      frame(b1_params[k], 1'b1, 4);
      chk("lat_param", last_valid_cyc - last_rise_cyc, SYNC + 2);
    end
    chk("b1_valid_cnt", valid_cnt - v0, 4);
    chk("b1_cmd", {24'd0, cmd_latched}, 32'hB1);
    check_shadow("b1");

    // Step 3: CS raised after 5 bits -> frame error only
    v0 = valid_cnt; f0 = fe_cnt;
    cs = 1'b0; tick(4);
    send_bits(8'hA5, 5, 1'b1, 4);
    tick(4); cs = 1'b1; tick(8);
    chk("ferr_pulse", fe_cnt - f0, 1);
    chk("ferr_no_valid", valid_cnt - v0, 0);
    chk("ferr_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    frame(8'h11, 1'b0, 4);
    chk("after_ferr_data", {24'd0, byte_data}, 32'h11);
    chk("after_ferr_iscmd", {31'd0, byte_is_cmd}, 32'd1);

    // Step 4: back-to-back bytes in one CS frame
    v0 = valid_cnt; f0 = fe_cnt;
    cs = 1'b0; tick(4);
    expect_byte(8'h29, 1'b0);
    send_bits(8'h29, 8, 1'b0, 4);
    expect_byte(8'h00, 1'b1);
    send_bits(8'h00, 8, 1'b1, 4);
    tick(4); cs = 1'b1; tick(8);
    chk("b2b_valid", valid_cnt - v0, 2);
    chk("b2b_no_ferr", fe_cnt - f0, 0);

    // Step 5: LCD reset in the middle of a byte
    frame(8'h2A, 1'b0, 3);
    frame(8'($urandom_range(0, 255)), 1'b1, 3);
    f0 = fe_cnt; v0 = valid_cnt;
    cs = 1'b0; tick(4);
    send_bits(8'($urandom_range(0, 255)), 3, 1'b1, 4);
    lcd_rstn = 1'b0;
    model_reset(1'b0);
    tick(6);
    chk("lcdrst_flag", {31'd0, lcd_in_reset}, 32'd1);
    chk("lcdrst_cmd", {24'd0, cmd_latched}, 32'd0);
    chk("lcdrst_state", {30'd0, state_dbg}, {30'd0, S_RESET});
    cs = 1'b1; tick(4);
    lcd_rstn = 1'b1; tick(8);
    chk("lcdrst_release", {31'd0, lcd_in_reset}, 32'd0);
    chk("lcdrst_no_ferr", fe_cnt - f0, 0);
    chk("lcdrst_no_valid", valid_cnt - v0, 0);
    check_shadow("lcdrst_keep");
    frame(8'h07, 1'b1, 4);
    chk("lcdrst_param_idx", {24'd0, param_idx}, 32'd0);

    // Step 6a: SCL activity with CS high is ignored
    v0 = valid_cnt; f0 = fe_cnt;
    for (int k = 0; k < 64; k++) begin
      mosi = 1'($urandom_range(0, 1)); dc_pin = 1'($urandom_range(0, 1));
      scl = 1'b1; tick(2);
      scl = 1'b0; tick(2);
    end
    tick(8);
    chk("idle_scl_valid", valid_cnt - v0, 0);
    chk("idle_scl_ferr", fe_cnt - f0, 0);

    // Step 6b: 258 parameters after one command -> index saturation
    cs = 1'b0; tick(4);
    r = 8'($urandom_range(0, 255));
    expect_byte(r, 1'b0);
    send_bits(r, 8, 1'b0, 3);
    for (int k = 0; k < 258; k++) begin
      r = 8'($urandom_range(0, 255));
      expect_byte(r, 1'b1);
      send_bits(r, 8, 1'b1, $urandom_range(2, 4));
    end
    tick(4); cs = 1'b1; tick(8);
    chk("sat_idx", {24'd0, param_idx}, 32'hFF);

    // Wrap-up
    check_shadow("final");
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
